frame_wrtr: RTL and testbench

- Write-side counterpart of the HDMI line buffer: accepts a 24-bit pixel stream and writes it into the system-memory frame region, from which the display path later reads.
- Pixels pass through a small synchronous FIFO, then go out as single-word Avalon-style writes with wait-request back-pressure.
- Each frame is aligned by a start-of-frame flag. One pulse is raised per completed frame.

---
 rtl/frame_wrtr_pkg.sv | 20 ++
 rtl/frame_wrtr_fifo.sv | 76 +++++++
 rtl/frame_wrtr.sv | 185 ++++++++++++++++++
 tb/tb_frame_wrtr.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_wrtr_pkg.sv
// Shared types for the frame writer: FSM state encoding and pixel width.
// No timing of its own; pure declarations.
// No flow control; imported by the frame writer and its FIFO user.
package frame_wrtr_pkg;

    // Width of one RGB pixel as carried on the input stream.
    localparam int PXL_W = 24;

    // Width of one FIFO entry: {sof, pixel}.
    localparam int ENTRY_W = PXL_W + 1;

    // IDLE: disabled/flushed, SYNC: hunting for start-of-frame,
    // RUN: writing pixels of the current frame to memory.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } frame_wrtr_state_t;

endpackage

// File: rtl/frame_wrtr_fifo.sv
// Purpose: generic synchronous first-word-fall-through FIFO with occupancy.
// Latency: a word pushed at edge N is visible on head_dat right after edge N.
// Backpressure: push is ignored while full, pop is ignored while empty.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           empties the FIFO at the next edge (wins over push/pop)
//   push, push_dat  write request and data
//   pop             consume the head word
//   head_dat        current head word (valid while empty=0)
//   full, empty     status flags
//   occ             number of stored words
module sync_fifo_fwft #(
    parameter int W     = 25,
    parameter int DEPTH = 16,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic             full,
    output logic             empty,
    output logic [OCC_W-1:0] occ
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OCC_W-1:0] occ_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (occ_q == OCC_W'(DEPTH));
    assign empty    = (occ_q == '0);
    assign occ      = occ_q;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    // Fall-through read: the head is always presented combinationally.
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Push and pop in the same cycle leave the count unchanged.
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/frame_wrtr.sv
// Purpose: writes a 24-bit pixel stream, frame-aligned on SOF, into a memory frame region.
// Latency: pixel accepted at cycle N can be on sys_mem_wren at N+1 (registered FIFO write, FWFT read).
// Backpressure: sys_mem_wait holds the write stable; FIFO fill drops pxl_ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wrtr_en                   block enable; low flushes and idles next cycle
//   pxl_valid/sof/data/ready  pixel stream in (valid/ready handshake)
//   sys_mem_*                 single-word Avalon-style write master (rden tied low)
//   frame_done                one-cycle pulse after the last word of a frame is written
//   frame_err, ff_ovrflw      sticky monitors: mid-frame SOF, push into a full FIFO
//   ff_occ                    FIFO occupancy
module frame_wrtr
    import frame_wrtr_pkg::*;
#(
    parameter int                        SYS_MEM_DATA_W     = 32,
    parameter int                        SYS_MEM_ADDR_W     = 27,
    parameter logic [SYS_MEM_ADDR_W-1:0] SYS_MEM_START_ADDR = '0,
    parameter logic [SYS_MEM_ADDR_W-1:0] SYS_MEM_STOP_ADDR  = SYS_MEM_ADDR_W'(921599),
    parameter int                        FF_DEPTH           = 16,
    parameter int                        FF_OCC_W           = $clog2(FF_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wrtr_en,
    input  logic                      pxl_valid,
    input  logic                      pxl_sof,
    input  logic [PXL_W-1:0]          pxl_data,
    output logic                      pxl_ready,
    input  logic                      sys_mem_wait,
    output logic                      sys_mem_wren,
    output logic                      sys_mem_rden,
    output logic [SYS_MEM_ADDR_W-1:0] sys_mem_addr,
    output logic [SYS_MEM_DATA_W-1:0] sys_mem_wdata,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic                      ff_ovrflw,
    output logic [FF_OCC_W-1:0]       ff_occ
);

    frame_wrtr_state_t         state_q;
    logic [SYS_MEM_ADDR_W-1:0] addr_q;
    logic                      frame_done_q;
    logic                      frame_err_q;
    logic                      ff_ovrflw_q;

    logic                      ff_full;
    logic                      ff_empty;
    logic                      ff_flush;
    logic                      ff_push;
    logic                      ff_pop;
    logic [ENTRY_W-1:0]        ff_head;
    logic                      head_sof;
    logic [PXL_W-1:0]          head_pxl;

    logic                      in_run;
    logic                      head_vld;
    logic                      wr_acc;
    logic                      sync_drop;
    logic                      mid_sof;
    logic                      at_stop;
    logic [SYS_MEM_ADDR_W-1:0] wr_addr;

    // ------------------------------------------------------------------
    // Pixel FIFO: entries are {sof, pixel}
    // ------------------------------------------------------------------
    sync_fifo_fwft #(
        .W     (ENTRY_W),
        .DEPTH (FF_DEPTH),
        .OCC_W (FF_OCC_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (ff_flush),
        .push     (ff_push),
        .push_dat ({pxl_sof, pxl_data}),
        .pop      (ff_pop),
        .head_dat (ff_head),
        .full     (ff_full),
        .empty    (ff_empty),
        .occ      (ff_occ)
    );

    assign head_sof = ff_head[PXL_W];
    assign head_pxl = ff_head[PXL_W-1:0];
    assign head_vld = ~ff_empty;
    assign in_run   = (state_q == RUN);

    // The source is only allowed in once the FSM has left IDLE, so nothing
    // can slip into the FIFO during the cycle it is being flushed.
    assign pxl_ready = wrtr_en & ~ff_full & (state_q != IDLE);
    assign ff_push   = pxl_valid & pxl_ready;

    // IDLE keeps the FIFO empty; dropping wrtr_en empties it at the next edge.
    assign ff_flush  = ~wrtr_en | (state_q == IDLE);

    // ------------------------------------------------------------------
    // Memory write port
    // ------------------------------------------------------------------
    assign sys_mem_wren = in_run & head_vld;
    assign sys_mem_rden = 1'b0;
    assign wr_acc       = sys_mem_wren & ~sys_mem_wait;

    // A SOF at the head always lands on the frame start, even mid-frame.
    // Both terms are stable while wait is high (head and addr_q only move
    // on an accepted write), so the address is held as the bus requires.
    assign wr_addr      = (sys_mem_wren & head_sof) ? SYS_MEM_START_ADDR : addr_q;
    assign sys_mem_addr = wr_addr;

    always_comb begin
        sys_mem_wdata              = '0;
        sys_mem_wdata[PXL_W-1:0]   = head_pxl;
    end

    // Leading non-SOF entries are thrown away while hunting for a frame.
    assign sync_drop = (state_q == SYNC) & head_vld & ~head_sof;
    assign ff_pop    = wr_acc | sync_drop;

    assign mid_sof   = sys_mem_wren & head_sof & (addr_q != SYS_MEM_START_ADDR);
    assign at_stop   = (wr_addr == SYS_MEM_STOP_ADDR);

    // ------------------------------------------------------------------
    // FSM, address counter and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= SYS_MEM_START_ADDR;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ff_ovrflw_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            // Monitoring only: a source that honours pxl_ready never trips this.
            if (pxl_valid && wrtr_en && ff_full) begin
                ff_ovrflw_q <= 1'b1;
            end

            if (!wrtr_en) begin
                // Any write still on the bus is abandoned; sticky flags stay.
                state_q <= IDLE;
                addr_q  <= SYS_MEM_START_ADDR;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= SYNC;
                        addr_q  <= SYS_MEM_START_ADDR;
                    end
                    SYNC: begin
                        // The SOF entry stays in the FIFO; RUN writes it.
                        if (head_vld && head_sof) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (mid_sof) begin
                            frame_err_q <= 1'b1;
                        end
                        if (wr_acc) begin
                            if (at_stop) begin
                                addr_q       <= SYS_MEM_START_ADDR;
                                frame_done_q <= 1'b1;
                                state_q      <= SYNC;
                            end else begin
                                // Continues from wr_addr so an aborted frame
                                // restarts at START+1 after its SOF word.
                                addr_q <= wr_addr + SYS_MEM_ADDR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        addr_q  <= SYS_MEM_START_ADDR;
                    end
                endcase
            end
        end
    end

    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign ff_ovrflw  = ff_ovrflw_q;

endmodule

// File: tb/tb_frame_wrtr.sv
// Testbench for frame_wrtr: directed scenarios plus randomized traffic,
// scored against a pixel-level model of frame placement.
// Small frame (0x10..0x17) and a 4-deep FIFO keep every boundary reachable.
module tb_frame_wrtr;

    localparam int AW    = 27;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int OW    = 3;
    localparam logic [AW-1:0] START = 27'h10;
    localparam logic [AW-1:0] STOP  = 27'h17;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrtr_en;
    logic          pxl_valid;
    logic          pxl_sof;
    logic [23:0]   pxl_data;
    logic          pxl_ready;
    logic          sys_mem_wait;
    logic          sys_mem_wren;
    logic          sys_mem_rden;
    logic [AW-1:0] sys_mem_addr;
    logic [DW-1:0] sys_mem_wdata;
    logic          frame_done;
    logic          frame_err;
    logic          ff_ovrflw;
    logic [OW-1:0] ff_occ;

    always #5 clk = ~clk;

    frame_wrtr #(
        .SYS_MEM_DATA_W     (DW),
        .SYS_MEM_ADDR_W     (AW),
        .SYS_MEM_START_ADDR (START),
        .SYS_MEM_STOP_ADDR  (STOP),
        .FF_DEPTH           (DEPTH),
        .FF_OCC_W           (OW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wrtr_en       (wrtr_en),
        .pxl_valid     (pxl_valid),
        .pxl_sof       (pxl_sof),
        .pxl_data      (pxl_data),
        .pxl_ready     (pxl_ready),
        .sys_mem_wait  (sys_mem_wait),
        .sys_mem_wren  (sys_mem_wren),
        .sys_mem_rden  (sys_mem_rden),
        .sys_mem_addr  (sys_mem_addr),
        .sys_mem_wdata (sys_mem_wdata),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .ff_ovrflw     (ff_ovrflw),
        .ff_occ        (ff_occ)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: where each accepted pixel must land in memory.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            done;
    } exp_t;

    exp_t        exp_q[$];
    bit          m_sync;
    int unsigned m_addr;
    bit          m_err;
    bit          model_on;

    function automatic void model_reset();
        m_sync = 1'b1;
        m_addr = START;
        exp_q.delete();
    endfunction

    function automatic void model_push(input bit sof, input logic [23:0] px);
        exp_t        e;
        int unsigned wa;
        if (m_sync && !sof) return;
        if (sof) begin
            if (!m_sync && m_addr != START) m_err = 1'b1;
            m_sync = 1'b0;
            wa = START;
        end else begin
            wa = m_addr;
        end
        e.a    = AW'(wa);
        e.d    = {8'h00, px};
        e.done = (wa == STOP);
        if (wa == STOP) begin
            m_sync = 1'b1;
            m_addr = START;
        end else begin
            m_addr = wa + 1;
        end
        exp_q.push_back(e);
    endfunction

    // Bus monitor state
    bit            hold;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    bit            done_pend;
    int            wr_cnt = 0;
    int            fd_cnt = 0;

    // One clock: sample mid-cycle, score the bus, then step past the edge.
    task automatic tick(output bit took);
        bit   acc;
        bit   np;
        exp_t e;
        @(negedge clk);
        chk("frame_done", frame_done, done_pend);
        if (frame_done) fd_cnt++;
        if (hold) begin
            chk("hold_wren", sys_mem_wren, 1);
            chk("hold_addr", sys_mem_addr, hold_a);
            chk("hold_wdata", sys_mem_wdata, hold_d);
        end
        acc  = sys_mem_wren && !sys_mem_wait;
        took = pxl_valid && pxl_ready;
        np   = 1'b0;
        if (acc) begin
            wr_cnt++;
            if (model_on) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_wr", sys_mem_wren, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", sys_mem_addr, e.a);
                    chk("wr_data", sys_mem_wdata, e.d);
                    np = e.done;
                end
            end
        end
        if (took && model_on) model_push(pxl_sof, pxl_data);
        hold   = sys_mem_wren && sys_mem_wait;
        hold_a = sys_mem_addr;
        hold_d = sys_mem_wdata;
        @(posedge clk);
        #1;
        done_pend = np;
        if (rst || !wrtr_en) begin
            hold      = 1'b0;
            done_pend = 1'b0;
        end
    endtask

    // raw=1 drives valid even when not ready (protocol violation on purpose).
    task automatic cyc(input bit en, input bit wt, input bit want, input bit sof,
                       input logic [23:0] d, input bit raw, output bit took);
        wrtr_en      = en;
        sys_mem_wait = wt;
        #1;
        pxl_sof   = sof;
        pxl_data  = d;
        pxl_valid = want && (raw || pxl_ready);
        tick(took);
        pxl_valid = 1'b0;
    endtask

    task automatic idle(input bit en, input bit wt);
        bit t;
        cyc(en, wt, 1'b0, 1'b0, 24'h0, 1'b0, t);
    endtask

    task automatic send(input bit wt, input bit sof, input logic [23:0] d);
        bit t;
        t = 1'b0;
        for (int i = 0; i < 100 && !t; i++) cyc(1'b1, wt, 1'b1, sof, d, 1'b0, t);
        if (!t) chk("push_timeout", pxl_ready, 1);
    endtask

    task automatic send_frame(input logic [23:0] base, input int n);
        for (int i = 0; i < n; i++) send(1'b0, i == 0, base + 24'(i));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((ff_occ != 0 || sys_mem_wren) && n < 100) begin
            idle(1'b1, 1'b0);
            n++;
        end
        if (n >= 100) chk("drain_timeout", ff_occ, 0);
        idle(1'b1, 1'b0);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_ready"}, pxl_ready, 0);
        chk({pfx, "_wren"}, sys_mem_wren, 0);
        chk({pfx, "_addr"}, sys_mem_addr, START);
        chk({pfx, "_done"}, frame_done, 0);
        chk({pfx, "_err"}, frame_err, 0);
        chk({pfx, "_ovr"}, ff_ovrflw, 0);
        chk({pfx, "_occ"}, ff_occ, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit            t;
        int            w0;
        logic [23:0]   d;
        rst = 1'b1; wrtr_en = 1'b0; pxl_valid = 1'b0; pxl_sof = 1'b0;
        pxl_data = '0; sys_mem_wait = 1'b0;
        hold = 1'b0; done_pend = 1'b0; m_err = 1'b0; model_on = 1'b1;
        model_reset();

        // Reset state
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check_reset_vals("rst");
        chk("rden", sys_mem_rden, 0);
        rst = 1'b0;

        // Frame of 8 with a single-pixel latency probe on the second pixel
        idle(1'b1, 1'b0);
        send(1'b0, 1'b1, 24'h000001);
        repeat (3) idle(1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 24'h000002, 1'b0, t);
        chk("lat_push", t, 1);
        chk("lat_wren", sys_mem_wren, 1);
        chk("lat_addr", sys_mem_addr, START + 1);
        for (int i = 3; i <= 8; i++) send(1'b0, 1'b0, 24'(i));
        drain();
        chk("f1_addr", sys_mem_addr, START);
        chk("f1_done", fd_cnt, 1);
        chk("f1_wrs", wr_cnt, 8);

        // Leading non-SOF pixels are discarded
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 24'hA1 + 24'(i));
        send_frame(24'h000011, 8);
        drain();
        chk("f2_wrs", wr_cnt - w0, 8);
        chk("f2_done", fd_cnt, 2);

        // Wait held 5 cycles on the write to START+2; FIFO fills meanwhile
        begin
            int idx;
            int hc;
            bit sawf;
            bit wt;
            idx = 0; hc = 0; sawf = 1'b0;
            for (int g = 0; g < 300; g++) begin
                wt = (hc < 5) && sys_mem_wren && (sys_mem_addr == START + 2);
                if (wt) hc++;
                if (ff_occ == 3'd4) begin
                    sawf = 1'b1;
                    chk("full_ready", pxl_ready, 0);
                end
                d = 24'h000301 + 24'(idx);
                cyc(1'b1, wt, idx < 8, idx == 0, d, 1'b0, t);
                if (t) idx++;
                if (idx == 8 && ff_occ == 0 && !sys_mem_wren) break;
            end
            idle(1'b1, 1'b0);
            chk("f3_sawfull", sawf, 1);
            chk("f3_waitcyc", hc, 5);
            chk("f3_pushed", idx, 8);
            chk("f3_ovr", ff_ovrflw, 0);
            chk("f3_done", fd_cnt, 3);
        end

        // SOF as 4th pixel aborts the frame and restarts at START
        send(1'b0, 1'b1, 24'h000401);
        send(1'b0, 1'b0, 24'h000402);
        send(1'b0, 1'b0, 24'h000403);
        for (int i = 0; i < 8; i++) send(1'b0, i == 0, 24'h000404 + 24'(i));
        drain();
        chk("f4_err", frame_err, 1);
        chk("f4_done", fd_cnt, 4);

        // Disable mid-frame with three pixels queued
        model_on = 1'b0;
        send(1'b1, 1'b1, 24'h000501);
        send(1'b1, 1'b0, 24'h000502);
        send(1'b1, 1'b0, 24'h000503);
        chk("dis_occ_before", ff_occ, 3);
        chk("dis_wren_before", sys_mem_wren, 1);
        idle(1'b0, 1'b1);
        chk("dis_wren", sys_mem_wren, 0);
        chk("dis_occ", ff_occ, 0);
        chk("dis_addr", sys_mem_addr, START);
        chk("dis_err_kept", frame_err, 1);
        model_reset();
        model_on = 1'b1;
        idle(1'b1, 1'b0);
        send(1'b0, 1'b0, 24'h0005A1);
        send(1'b0, 1'b0, 24'h0005A2);
        send_frame(24'h000601, 8);
        drain();
        chk("f5_done", fd_cnt, 5);

        // Reset in the middle of a stalled write, with overflow forced first
        model_on = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, i == 0, 24'h000701 + 24'(i));
        chk("ovf_occ", ff_occ, 4);
        chk("ovf_ready", pxl_ready, 0);
        chk("ovf_wren", sys_mem_wren, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 24'h000705, 1'b1, t);
        chk("ovf_flag", ff_ovrflw, 1);
        rst = 1'b1;
        idle(1'b1, 1'b1);
        check_reset_vals("rst2");
        rst = 1'b0;
        m_err = 1'b0;
        model_reset();
        model_on = 1'b1;

        // Randomized traffic: random gaps, wait-requests and SOF placement
        for (int r = 0; r < 6; r++) begin
            int pc;
            bit sof;
            pc = 0;
            idle(1'b1, 1'b0);
            for (int c = 0; c < 150; c++) begin
                sof = (((pc >= 8) || (pc == 0)) && ($urandom % 4 != 0)) || ($urandom % 16 == 0);
                d   = 24'($urandom);
                cyc(1'b1, ($urandom % 3) == 0, ($urandom % 4) != 0, sof, d, 1'b0, t);
                if (t) pc = sof ? 1 : pc + 1;
            end
            drain();
            chk("rnd_err", frame_err, m_err);
            chk("rnd_ovr", ff_ovrflw, 0);
            chk("rnd_left", exp_q.size(), 0);
            idle(1'b0, 1'b0);
            chk("rnd_addr", sys_mem_addr, START);
            model_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
